ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch stage: holds the architectural fetch PC and issues one word read at a time to the instruction memory port. It presents `{pc, inst}` to decode over the stage handshake (stage_if master side) and accepts branch/jump redirection from execute (pc_redirect_if slave side). At most one memory request is outstanding. Responses made stale by a redirect are discarded.

## Interface
- `RESET_PC`, 32'h8000_0000, PC fetched first after reset.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset: one clock, synchronous, active-low.
- `redirect_valid`  in  1  redirect request (pc_redirect_if.valid).
- `redirect_target`  in  32  new PC (pc_redirect_if.target); bits [1:0] ignored.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  word address; bits [1:0] always 0.
- `imem_rsp_valid`  in  1  read data valid, exactly one per accepted request, any latency ≥1 cycle.
- `imem_rsp_data`  in  32  instruction word.
- `imem_rsp_err`  in  1  access fault; present only with IFU_FAULT_EN.
- `out_valid`  out  1  stage_if.valid toward decode.
- `out_ready`  in  1  stage_if.ready from decode.
- `out_pc`  out  32  PC of presented instruction.
- `out_inst`  out  32  presented instruction.
- `out_fault`  out  1  instruction carries access fault; present only with IFU_FAULT_EN.

## Operation
- Registers: `pc`, `state`, `discard`, output register `{out_pc, out_inst, out_fault}`.
- States: BOOT, REQ, WAIT, HOLD; HALT only with IFU_FAULT_EN.
- BOOT: reset state, no outputs asserted. Goes unconditionally to REQ next cycle.
- REQ: `imem_req_valid`=1 and `imem_req_addr`=`pc`. On `imem_req_ready`, go to WAIT.
- WAIT: on `imem_rsp_valid`:
  - If `discard`=1: clear `discard`, go to REQ.
  - Else: load the output register with `pc` and the data, go to HOLD.
- HOLD: `out_valid`=1 and the payload is stable. On `out_valid && out_ready`: `pc <= pc+4` (32-bit wrap, FFFF_FFFC→0000_0000), go to REQ.
- Redirect has priority over every other event in the same cycle. `pc <= {redirect_target[31:2],2'b00}`.
  - BOOT/REQ without request handshake, HOLD, HALT: go to REQ. An instruction in HOLD is dropped, even if `out_ready`=1 that cycle. `pc` does not increment.
  - REQ with request handshake the same cycle: the request goes out with the old `pc`. Set `discard`, go to WAIT.
  - WAIT without response: set `discard`, stay in WAIT.
  - WAIT with response the same cycle: drop the response, clear `discard`, go to REQ.
- `imem_req_valid`, once asserted, stays asserted with stable address until accepted or until a redirect.
- `imem_rsp_valid` outside WAIT is a protocol violation. Bench asserts it never happens.

## Timing
- Reset values: `state`=BOOT, `pc`=RESET_PC, `discard`=0, `out_valid`=0, `imem_req_valid`=0, `out_pc`=0, `out_inst`=0, `out_fault`=0.
- First request is issued in the second cycle after `rst_n` rises: BOOT lasts 1 cycle.
- Asserting `rst_n`=0 mid-operation returns to reset values at the next edge. Any in-flight response arriving after reset is ignored: state is not WAIT.
- Latency:
  - Request accepted at cycle N and response at N+k give `out_valid` at N+k+1.
  - Handoff at cycle M gives the next request at M+1.
  - Best-case throughput: one instruction per 3 cycles.
- Redirect at cycle N gives a request with the target at N+1 (from REQ/HOLD) or after the stale response retires.
- Outputs are registered or decoded from `state` only. There is no combinational path from `out_ready` or `imem_rsp_*` to any output.

## Configuration
- `IFU_FAULT_EN` defined:
  - Ports `imem_rsp_err` and `out_fault` exist, and `imem_rsp_err` is captured into `out_fault`.
  - After a faulting instruction is handed off, go to HALT. HALT issues no requests and holds `out_valid`=0 until a redirect.
  - A discarded faulting response is ignored.
- Undefined:
  - Ports and the HALT state are absent.
  - Behaviour is as if `imem_rsp_err`=0.

## Test plan
- Reset release with 1-cycle memory and `out_ready`=1 → outputs `{8000_0000, i0}`, `{8000_0004, i1}`, `{8000_0008, i2}` at 3-cycle spacing. First `out_valid` 3 cycles after BOOT exits.
- `out_ready`=0 for 5 cycles in HOLD → `out_valid`=1 with payload unchanged, no new `imem_req_valid`, `pc` not incremented.
- Redirect to 8000_0102 while WAIT with 4-cycle latency → stale data never appears on output. Next request address is 8000_0100.
- Redirect in HOLD with `out_ready`=1 the same cycle → no handoff. Next request address is the target.
- PC wrap: redirect to FFFF_FFFC → after handoff, next request address is 0000_0000.
- IFU_FAULT_EN: response with `imem_rsp_err`=1 at 8000_0010 → `out_fault`=1, then no requests. Redirect to 8000_0200 resumes fetch.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bundle: instruction-memory port, decode handshake and execute redirect.
// Fault signals exist only when IFU_FAULT_EN is defined.
interface ifu_fetch_if;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
`ifdef IFU_FAULT_EN
   logic        imem_rsp_err;
   logic        out_fault;
`endif

   modport master (
      input  redirect_valid,
      input  redirect_target,
      output imem_req_valid,
      input  imem_req_ready,
      output imem_req_addr,
      input  imem_rsp_valid,
      input  imem_rsp_data,
      output out_valid,
      input  out_ready,
      output out_pc,
      output out_inst
`ifdef IFU_FAULT_EN
      ,
      input  imem_rsp_err,
      output out_fault
`endif
   );

   modport slave (
      output redirect_valid,
      output redirect_target,
      input  imem_req_valid,
      output imem_req_ready,
      input  imem_req_addr,
      output imem_rsp_valid,
      output imem_rsp_data,
      input  out_valid,
      output out_ready,
      input  out_pc,
      input  out_inst
`ifdef IFU_FAULT_EN
      ,
      output imem_rsp_err,
      input  out_fault
`endif
   );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding word read, registered {pc, inst} toward decode,
// redirect with stale-response discard. Access-fault capture and HALT exist only with IFU_FAULT_EN.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input logic        clk,
   input logic        rst_n,
   ifu_fetch_if.master bus
);

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_REQ,
      ST_WAIT,
      ST_HOLD
`ifdef IFU_FAULT_EN
      ,
      ST_HALT
`endif
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        discard_q, discard_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic [31:0] out_inst_q, out_inst_d;
`ifdef IFU_FAULT_EN
   logic        out_fault_q, out_fault_d;
`endif

   logic [31:0] tgt_pc;
   logic        unused_tgt_lsb;

   assign tgt_pc         = {bus.redirect_target[31:2], 2'b00};
   assign unused_tgt_lsb = ^bus.redirect_target[1:0];

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      discard_d  = discard_q;
      out_pc_d   = out_pc_q;
      out_inst_d = out_inst_q;
`ifdef IFU_FAULT_EN
      out_fault_d = out_fault_q;
`endif
      case (state_q)
         ST_BOOT: begin
            state_d = ST_REQ;
            if (bus.redirect_valid) pc_d = tgt_pc;
         end
         ST_REQ: begin
            if (bus.imem_req_ready) state_d = ST_WAIT;
            // An accepted request still carries the old pc; its response must be dropped.
            if (bus.redirect_valid) begin
               pc_d = tgt_pc;
               if (bus.imem_req_ready) discard_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (bus.redirect_valid) begin
               pc_d = tgt_pc;
               if (bus.imem_rsp_valid) begin
                  discard_d = 1'b0;
                  state_d   = ST_REQ;
               end else begin
                  discard_d = 1'b1;
               end
            end else if (bus.imem_rsp_valid) begin
               discard_d = 1'b0;
               if (discard_q) begin
                  state_d = ST_REQ;
               end else begin
                  out_pc_d   = pc_q;
                  out_inst_d = bus.imem_rsp_data;
`ifdef IFU_FAULT_EN
                  out_fault_d = bus.imem_rsp_err;
`endif
                  state_d    = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (bus.redirect_valid) begin
               pc_d    = tgt_pc;
               state_d = ST_REQ;
            end else if (bus.out_ready) begin
               pc_d    = pc_q + 32'd4;
               state_d = ST_REQ;
`ifdef IFU_FAULT_EN
               if (out_fault_q) state_d = ST_HALT;
`endif
            end
         end
`ifdef IFU_FAULT_EN
         ST_HALT: begin
            if (bus.redirect_valid) begin
               pc_d    = tgt_pc;
               state_d = ST_REQ;
            end
         end
`endif
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_PC;
         discard_q  <= 1'b0;
         out_pc_q   <= '0;
         out_inst_q <= '0;
`ifdef IFU_FAULT_EN
         out_fault_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         discard_q  <= discard_d;
         out_pc_q   <= out_pc_d;
         out_inst_q <= out_inst_d;
`ifdef IFU_FAULT_EN
         out_fault_q <= out_fault_d;
`endif
      end
   end

   assign bus.imem_req_valid = (state_q == ST_REQ);
   assign bus.imem_req_addr  = pc_q;
   assign bus.out_valid      = (state_q == ST_HOLD);
   assign bus.out_pc         = out_pc_q;
   assign bus.out_inst       = out_inst_q;
`ifdef IFU_FAULT_EN
   assign bus.out_fault      = out_fault_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: variable-latency memory responder plus handoff/request logs.
// Define IFU_FAULT_EN to also exercise fault capture and HALT.
module tb_ifu_fetch;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ifu_fetch_if bus();
   ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int          n_cmp = 0;
   int          n_err = 0;
   int unsigned cyc   = 0;
   int unsigned lat;
   logic        mem_ready;
   logic [31:0] err_addr;
   logic [31:0] stale_pc;
   logic        stale_seen;

   logic [31:0] req_addr_q[$];
   int unsigned req_cyc_q[$];
   logic [31:0] ho_pc_q[$];
   logic [31:0] ho_inst_q[$];
   int unsigned ho_cyc_q[$];
   logic        ho_fault_q[$];

   assign bus.imem_req_ready = mem_ready;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Responder and monitors share one process so their order is fixed, #1 after the
   // falling edge where the tests drive their inputs. Logged cycles are the next rising edge.
   initial begin
      logic        pend;
      int unsigned cnt;
      logic [31:0] paddr;
      logic        fault_now;
      pend = 1'b0; cnt = 0; paddr = '0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
`ifdef IFU_FAULT_EN
      bus.imem_rsp_err   = 1'b0;
`endif
      forever begin
         @(negedge clk);
         #1;
         bus.imem_rsp_valid = 1'b0;
         if (!rst_n) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               cnt--;
               if (cnt == 0) begin
                  bus.imem_rsp_valid = 1'b1;
                  bus.imem_rsp_data  = inst_of(paddr);
`ifdef IFU_FAULT_EN
                  bus.imem_rsp_err   = (paddr == err_addr);
`endif
                  pend = 1'b0;
               end
            end
            if (bus.imem_req_valid && mem_ready) begin
               pend  = 1'b1;
               cnt   = lat;
               paddr = bus.imem_req_addr;
               req_addr_q.push_back(bus.imem_req_addr);
               req_cyc_q.push_back(cyc + 1);
            end
         end
         if (rst_n && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
`ifdef IFU_FAULT_EN
            fault_now = bus.out_fault;
`else
            fault_now = 1'b0;
`endif
            ho_pc_q.push_back(bus.out_pc);
            ho_inst_q.push_back(bus.out_inst);
            ho_cyc_q.push_back(cyc + 1);
            ho_fault_q.push_back(fault_now);
         end
         if (bus.out_valid && bus.out_pc == stale_pc) stale_seen = 1'b1;
         if (bus.imem_rsp_valid) begin
            n_cmp++;
            if ({bus.imem_req_valid, bus.out_valid} !== 2'b00) begin
               n_err++;
               $display("FAIL rsp_outside_wait at cyc %0d: req_valid=%b out_valid=%b, want both 0",
                        cyc, bus.imem_req_valid, bus.out_valid);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic goto_cyc(input int unsigned t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic clear_logs();
      req_addr_q.delete(); req_cyc_q.delete();
      ho_pc_q.delete(); ho_inst_q.delete(); ho_cyc_q.delete(); ho_fault_q.delete();
      stale_seen = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = '0;
      bus.out_ready       = 1'b0;
      mem_ready           = 1'b1;
      lat                 = 1;
      err_addr            = 32'h0000_0001;
      stale_pc            = 32'h0000_0001;
      step(2);
      clear_logs();
   endtask

   task automatic release_rst(output int unsigned r);
      rst_n = 1'b1;
      r = cyc;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid got %b want 0", bus.imem_req_valid); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.out_pc !== 32'h0) begin n_err++; $display("FAIL reset_out_pc got %h want 00000000", bus.out_pc); end
      n_cmp++; if (bus.out_inst !== 32'h0) begin n_err++; $display("FAIL reset_out_inst got %h want 00000000", bus.out_inst); end
`ifdef IFU_FAULT_EN
      n_cmp++; if (bus.out_fault !== 1'b0) begin n_err++; $display("FAIL reset_out_fault got %b want 0", bus.out_fault); end
`endif
   endtask

   task automatic test_back_to_back();
      int unsigned r;
      do_reset();
      bus.out_ready = 1'b1;
      release_rst(r);
      goto_cyc(r + 1);
      n_cmp++; if (bus.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first_req_valid got %b want 1", bus.imem_req_valid); end
      goto_cyc(r + 12);
      n_cmp++; if (req_cyc_q[0] !== r + 2) begin n_err++; $display("FAIL b2b_first_req_cyc got %0d want %0d", req_cyc_q[0], r + 2); end
      n_cmp++; if (req_addr_q[0] !== 32'h8000_0000) begin n_err++; $display("FAIL b2b_first_req_addr got %h want 80000000", req_addr_q[0]); end
      n_cmp++; if (ho_pc_q.size() != 3) begin n_err++; $display("FAIL b2b_handoff_count got %0d want 3", ho_pc_q.size()); end
      for (int i = 0; i < 3; i++) begin
         logic [31:0] epc;
         epc = 32'h8000_0000 + 32'(4 * i);
         n_cmp++; if (ho_pc_q[i] !== epc) begin n_err++; $display("FAIL b2b_pc[%0d] got %h want %h", i, ho_pc_q[i], epc); end
         n_cmp++; if (ho_inst_q[i] !== inst_of(epc)) begin n_err++; $display("FAIL b2b_inst[%0d] got %h want %h", i, ho_inst_q[i], inst_of(epc)); end
         n_cmp++; if (ho_cyc_q[i] !== r + 4 + 3 * i) begin n_err++; $display("FAIL b2b_cyc[%0d] got %0d want %0d", i, ho_cyc_q[i], r + 4 + 3 * i); end
      end
   endtask

   task automatic test_req_backpressure();
      int unsigned r;
      do_reset();
      bus.out_ready = 1'b1;
      mem_ready = 1'b0;
      release_rst(r);
      goto_cyc(r + 1);
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (bus.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL bp_req_valid[%0d] got %b want 1", i, bus.imem_req_valid); end
         n_cmp++; if (bus.imem_req_addr !== 32'h8000_0000) begin n_err++; $display("FAIL bp_req_addr[%0d] got %h want 80000000", i, bus.imem_req_addr); end
         step(1);
      end
      mem_ready = 1'b1;
      goto_cyc(r + 6);
      n_cmp++; if (req_cyc_q[0] !== r + 5) begin n_err++; $display("FAIL bp_accept_cyc got %0d want %0d", req_cyc_q[0], r + 5); end
   endtask

   task automatic test_hold_stall();
      int unsigned r;
      do_reset();
      release_rst(r);
      goto_cyc(r + 3);
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL stall_out_valid[%0d] got %b want 1", i, bus.out_valid); end
         n_cmp++; if (bus.out_pc !== 32'h8000_0000) begin n_err++; $display("FAIL stall_out_pc[%0d] got %h want 80000000", i, bus.out_pc); end
         n_cmp++; if (bus.out_inst !== inst_of(32'h8000_0000)) begin n_err++; $display("FAIL stall_out_inst[%0d] got %h want %h", i, bus.out_inst, inst_of(32'h8000_0000)); end
         n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL stall_req_valid[%0d] got %b want 0", i, bus.imem_req_valid); end
         step(1);
      end
      bus.out_ready = 1'b1;
      goto_cyc(r + 12);
      n_cmp++; if (ho_cyc_q[0] !== r + 9) begin n_err++; $display("FAIL stall_handoff_cyc got %0d want %0d", ho_cyc_q[0], r + 9); end
      n_cmp++; if (req_addr_q.size() != 2) begin n_err++; $display("FAIL stall_req_count got %0d want 2", req_addr_q.size()); end
      n_cmp++; if (req_addr_q[1] !== 32'h8000_0004) begin n_err++; $display("FAIL stall_next_addr got %h want 80000004", req_addr_q[1]); end
      n_cmp++; if (req_cyc_q[1] !== r + 10) begin n_err++; $display("FAIL stall_next_cyc got %0d want %0d", req_cyc_q[1], r + 10); end
   endtask

   task automatic test_redirect_wait();
      int unsigned r;
      do_reset();
      lat = 4;
      bus.out_ready = 1'b1;
      stale_pc = 32'h8000_0000;
      release_rst(r);
      goto_cyc(r + 3);
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'h8000_0102;
      step(1);
      bus.redirect_valid  = 1'b0;
      goto_cyc(r + 14);
      n_cmp++; if (req_addr_q[1] !== 32'h8000_0100) begin n_err++; $display("FAIL rdw_next_addr got %h want 80000100", req_addr_q[1]); end
      n_cmp++; if (req_cyc_q[1] !== r + 7) begin n_err++; $display("FAIL rdw_next_cyc got %0d want %0d", req_cyc_q[1], r + 7); end
      n_cmp++; if (ho_pc_q.size() != 1) begin n_err++; $display("FAIL rdw_handoff_count got %0d want 1", ho_pc_q.size()); end
      n_cmp++; if (ho_pc_q[0] !== 32'h8000_0100) begin n_err++; $display("FAIL rdw_pc got %h want 80000100", ho_pc_q[0]); end
      n_cmp++; if (ho_inst_q[0] !== inst_of(32'h8000_0100)) begin n_err++; $display("FAIL rdw_inst got %h want %h", ho_inst_q[0], inst_of(32'h8000_0100)); end
      n_cmp++; if (stale_seen !== 1'b0) begin n_err++; $display("FAIL rdw_stale_seen got %b want 0", stale_seen); end
   endtask

   task automatic test_redirect_req();
      int unsigned r;
      do_reset();
      lat = 3;
      bus.out_ready = 1'b1;
      stale_pc = 32'h8000_0000;
      release_rst(r);
      goto_cyc(r + 1);
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'h8000_0800;
      step(1);
      bus.redirect_valid  = 1'b0;
      goto_cyc(r + 12);
      n_cmp++; if (req_addr_q[0] !== 32'h8000_0000) begin n_err++; $display("FAIL rdr_old_addr got %h want 80000000", req_addr_q[0]); end
      n_cmp++; if (req_addr_q[1] !== 32'h8000_0800) begin n_err++; $display("FAIL rdr_next_addr got %h want 80000800", req_addr_q[1]); end
      n_cmp++; if (req_cyc_q[1] !== r + 6) begin n_err++; $display("FAIL rdr_next_cyc got %0d want %0d", req_cyc_q[1], r + 6); end
      n_cmp++; if (ho_pc_q[0] !== 32'h8000_0800) begin n_err++; $display("FAIL rdr_pc got %h want 80000800", ho_pc_q[0]); end
      n_cmp++; if (ho_cyc_q[0] !== r + 10) begin n_err++; $display("FAIL rdr_handoff_cyc got %0d want %0d", ho_cyc_q[0], r + 10); end
      n_cmp++; if (stale_seen !== 1'b0) begin n_err++; $display("FAIL rdr_stale_seen got %b want 0", stale_seen); end
   endtask

   task automatic test_redirect_hold();
      int unsigned r;
      do_reset();
      release_rst(r);
      goto_cyc(r + 4);
      bus.out_ready       = 1'b1;
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'h8000_0400;
      step(1);
      bus.redirect_valid  = 1'b0;
      goto_cyc(r + 9);
      n_cmp++; if (ho_pc_q.size() != 1) begin n_err++; $display("FAIL rdh_handoff_count got %0d want 1", ho_pc_q.size()); end
      n_cmp++; if (ho_pc_q[0] !== 32'h8000_0400) begin n_err++; $display("FAIL rdh_pc got %h want 80000400", ho_pc_q[0]); end
      n_cmp++; if (req_addr_q[1] !== 32'h8000_0400) begin n_err++; $display("FAIL rdh_next_addr got %h want 80000400", req_addr_q[1]); end
      n_cmp++; if (req_cyc_q[1] !== r + 6) begin n_err++; $display("FAIL rdh_next_cyc got %0d want %0d", req_cyc_q[1], r + 6); end
   endtask

   task automatic test_pc_wrap();
      int unsigned r;
      do_reset();
      bus.out_ready       = 1'b1;
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'hFFFF_FFFF;
      release_rst(r);
      step(1);
      bus.redirect_valid  = 1'b0;
      goto_cyc(r + 8);
      n_cmp++; if (req_addr_q[0] !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_first_addr got %h want fffffffc", req_addr_q[0]); end
      n_cmp++; if (req_addr_q[1] !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_next_addr got %h want 00000000", req_addr_q[1]); end
      n_cmp++; if (req_cyc_q[1] !== r + 5) begin n_err++; $display("FAIL wrap_next_cyc got %0d want %0d", req_cyc_q[1], r + 5); end
      n_cmp++; if (ho_pc_q[1] !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_pc got %h want 00000000", ho_pc_q[1]); end
   endtask

   task automatic test_mid_reset();
      int unsigned r;
      do_reset();
      bus.out_ready = 1'b1;
      release_rst(r);
      goto_cyc(r + 6);
      rst_n = 1'b0;
      step(1);
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_out_valid got %b want 0", bus.out_valid); end
      n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL mrst_req_valid got %b want 0", bus.imem_req_valid); end
      n_cmp++; if (bus.out_pc !== 32'h0) begin n_err++; $display("FAIL mrst_out_pc got %h want 00000000", bus.out_pc); end
      n_cmp++; if (bus.out_inst !== 32'h0) begin n_err++; $display("FAIL mrst_out_inst got %h want 00000000", bus.out_inst); end
      clear_logs();
      release_rst(r);
      goto_cyc(r + 3);
      n_cmp++; if (req_addr_q.size() != 1) begin n_err++; $display("FAIL mrst_req_count got %0d want 1", req_addr_q.size()); end
      n_cmp++; if (req_addr_q[0] !== 32'h8000_0000) begin n_err++; $display("FAIL mrst_req_addr got %h want 80000000", req_addr_q[0]); end
      n_cmp++; if (req_cyc_q[0] !== r + 2) begin n_err++; $display("FAIL mrst_req_cyc got %0d want %0d", req_cyc_q[0], r + 2); end
   endtask

`ifdef IFU_FAULT_EN
   task automatic test_fault();
      int unsigned r;
      do_reset();
      bus.out_ready       = 1'b1;
      err_addr            = 32'h8000_0010;
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'h8000_0010;
      release_rst(r);
      step(1);
      bus.redirect_valid  = 1'b0;
      goto_cyc(r + 3);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL flt_out_valid got %b want 1", bus.out_valid); end
      n_cmp++; if (bus.out_fault !== 1'b1) begin n_err++; $display("FAIL flt_out_fault got %b want 1", bus.out_fault); end
      goto_cyc(r + 10);
      n_cmp++; if (req_addr_q.size() != 1) begin n_err++; $display("FAIL flt_halt_req_count got %0d want 1", req_addr_q.size()); end
      n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL flt_halt_req_valid got %b want 0", bus.imem_req_valid); end
      n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flt_halt_out_valid got %b want 0", bus.out_valid); end
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = 32'h8000_0200;
      step(1);
      bus.redirect_valid  = 1'b0;
      goto_cyc(r + 15);
      n_cmp++; if (ho_fault_q[0] !== 1'b1) begin n_err++; $display("FAIL flt_first_fault got %b want 1", ho_fault_q[0]); end
      n_cmp++; if (req_addr_q[1] !== 32'h8000_0200) begin n_err++; $display("FAIL flt_resume_addr got %h want 80000200", req_addr_q[1]); end
      n_cmp++; if (req_cyc_q[1] !== r + 12) begin n_err++; $display("FAIL flt_resume_cyc got %0d want %0d", req_cyc_q[1], r + 12); end
      n_cmp++; if (ho_pc_q[1] !== 32'h8000_0200) begin n_err++; $display("FAIL flt_resume_pc got %h want 80000200", ho_pc_q[1]); end
      n_cmp++; if (ho_fault_q[1] !== 1'b0) begin n_err++; $display("FAIL flt_resume_fault got %b want 0", ho_fault_q[1]); end
   endtask
`endif

   initial begin
      rst_n               = 1'b0;
      bus.redirect_valid  = 1'b0;
      bus.redirect_target = '0;
      bus.out_ready       = 1'b0;
      mem_ready           = 1'b1;
      lat                 = 1;
      err_addr            = 32'h0000_0001;
      stale_pc            = 32'h0000_0001;
      stale_seen          = 1'b0;
      test_reset();
      test_back_to_back();
      test_req_backpressure();
      test_hold_stall();
      test_redirect_wait();
      test_redirect_req();
      test_redirect_hold();
      test_pc_wrap();
      test_mid_reset();
`ifdef IFU_FAULT_EN
      test_fault();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
